mem_responder: RTL

- Unified instruction/data memory that sits on the far side of the multicycle core's memory port.
- Accepts one request at a time: an instruction fetch, load or store.
- Inserts a configurable number of wait states, performs byte/half/word access with RISC-V load extension and store lane merging, and returns one response pulse.
- Flags misaligned, out-of-range or illegal-size accesses instead of performing them.

---
 rtl/mem_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory behind the multicycle core's
// memory port. One request at a time, WAIT_STATES wait cycles, one-cycle
// response pulse, RISC-V load extension and store lane merging.
// Optional macro MEM_RESPONDER_STATS_EN adds load/store/error counters.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errors
`endif
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               accept;
  logic               req_err;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         off_q;
  logic [2:0]         funct3_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP) && !reset;
  assign accept    = req_valid && req_ready;

  // Classify the incoming request: misaligned, illegal size or out of range.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = req_addr[0];
        3'b010:  req_err = |req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = req_addr[0];
        3'b010:         req_err = |req_addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;
  end

  // Next-state logic: errors skip straight to RESP, zero wait states skip WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)              state_d = RESP;
          else if (WAIT_STATES > 0) state_d = WAIT;
          else                      state_d = ACCESS;
        end
      end
      WAIT:    if (cnt_q == 4'd0) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the request at accept and count down the wait states.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      idx_q    <= req_addr[IDX_W+1:2];
      off_q    <= req_addr[1:0];
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
      cnt_q    <= WAIT_INIT;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Replicate store data across lanes and select the byte enables.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << off_q;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: wr_be = 4'b1111;
    endcase
  end

  // Commit the selected store lanes at the edge ending ACCESS; reset wins.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents are undefined until written.
    if (!reset && state_q == ACCESS && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Select the addressed lane and apply sign or zero extension.
  always_comb begin
    rd_word = mem[idx_q];
    ld_byte = rd_word[8*off_q +: 8];
    ld_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Response data and error flag; held until the next response is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept && req_err) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b1;
    end else if (state_q == ACCESS) begin
      rsp_rdata <= we_q ? 32'd0 : ld_data;
      rsp_err   <= 1'b0;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  // Saturating per-outcome counters, stepped on each response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errors <= 32'd0;
    end else if (rsp_valid) begin
      if (rsp_err) begin
        if (stat_errors != 32'hFFFF_FFFF) stat_errors <= stat_errors + 32'd1;
      end else if (we_q) begin
        if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule
